// File: rtl/link_mode_pkg.sv
// Shared types and defaults for the 8G/16G receive-path mode sequencer.
package link_mode_pkg;

    typedef enum logic [1:0] {
        STABLE = 2'h0,
        DRAIN  = 2'h1,
        SETTLE = 2'h2
    } mode_state_e;

    localparam int unsigned DRAIN_TO_DEF   = 1024;
    localparam int unsigned SETTLE_CYC_DEF = 16;

endpackage

// File: rtl/frame_tracker.sv
// Tracks whether an observed stream is currently inside a frame.
module frame_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic sop,
    input  logic eop,
    input  logic valid,
    output logic in_frame
);

    // eop wins, so a single-beat sop&eop frame leaves the tracker closed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame <= 1'b0;
        end else if (valid && eop) begin
            in_frame <= 1'b0;
        end else if (valid && sop) begin
            in_frame <= 1'b1;
        end
    end

endmodule

// File: rtl/link_mode_sequencer.sv
// Switches the receive path between MTIP (8G) and FMAC (16G) only between frames,
// with a bounded drain wait and a post-switch settle window.
module link_mode_sequencer
    import link_mode_pkg::*;
#(
    parameter int unsigned DRAIN_TO   = DRAIN_TO_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic        iCLK_CORE,
    input  logic        iRST_LINK_FC_CORE_N,
    input  logic        mode_req,
    input  logic        mif_sop,
    input  logic        mif_eop,
    input  logic        mif_valid,
    input  logic        fmac_sop,
    input  logic        fmac_eop,
    input  logic        fmac_valid,
    output logic        mtip_enable,
    output logic        mode_busy,
    output logic        mode_switch_done,
    output logic        drain_timeout,
    output logic [15:0] switch_cnt
);

    localparam int unsigned DCW = $clog2(DRAIN_TO);
    localparam int unsigned SCW = $clog2(SETTLE_CYC + 1);
    localparam logic [DCW-1:0] DRAIN_LAST  = DCW'(DRAIN_TO - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    mode_state_e    state;
    logic [DCW-1:0] drain_cnt;
    logic [SCW-1:0] settle_cnt;

    logic mif_in_frame;
    logic fmac_in_frame;
    logic act_in_frame;
    logic act_sop;
    logic idle;

    frame_tracker u_mif_tracker (
        .clk      (iCLK_CORE),
        .rst_n    (iRST_LINK_FC_CORE_N),
        .sop      (mif_sop),
        .eop      (mif_eop),
        .valid    (mif_valid),
        .in_frame (mif_in_frame)
    );

    frame_tracker u_fmac_tracker (
        .clk      (iCLK_CORE),
        .rst_n    (iRST_LINK_FC_CORE_N),
        .sop      (fmac_sop),
        .eop      (fmac_eop),
        .valid    (fmac_valid),
        .in_frame (fmac_in_frame)
    );

    // A frame starting this cycle on the active path is not a safe switch point
    assign act_in_frame = mtip_enable ? mif_in_frame : fmac_in_frame;
    assign act_sop      = mtip_enable ? (mif_sop && mif_valid) : (fmac_sop && fmac_valid);
    assign idle         = !act_in_frame && !act_sop;

    always_ff @(posedge iCLK_CORE or negedge iRST_LINK_FC_CORE_N) begin
        if (!iRST_LINK_FC_CORE_N) begin
            state            <= STABLE;
            mtip_enable      <= 1'b0;
            mode_busy        <= 1'b0;
            mode_switch_done <= 1'b0;
            drain_timeout    <= 1'b0;
            switch_cnt       <= 16'h0000;
            drain_cnt        <= '0;
            settle_cnt       <= '0;
        end else begin
            mode_switch_done <= 1'b0;
            drain_timeout    <= 1'b0;
            case (state)
                STABLE: begin
                    if (mode_req != mtip_enable) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        mode_busy <= 1'b1;
                    end else begin
                        mode_busy <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (mode_req == mtip_enable) begin
                        state     <= STABLE;
                        mode_busy <= 1'b0;
                    end else if (idle || (drain_cnt == DRAIN_LAST)) begin
                        mtip_enable   <= ~mtip_enable;
                        drain_timeout <= ~idle;
                        if (switch_cnt != 16'hFFFF) begin
                            switch_cnt <= switch_cnt + 16'd1;
                        end
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state            <= STABLE;
                        mode_busy        <= 1'b0;
                        mode_switch_done <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= STABLE;
                    mode_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_mode_sequencer.sv
// Directed bench: dut_a uses default timing, dut_b a short drain timeout.
module tb_link_mode_sequencer;

    logic clk;
    logic rst_n = 1'b1;

    logic a_req, a_msop, a_meop, a_mval, a_fsop, a_feop, a_fval;
    logic a_en, a_busy, a_done, a_to;
    logic [15:0] a_cnt;

    logic b_req, b_msop, b_meop, b_mval, b_fsop, b_feop, b_fval;
    logic b_en, b_busy, b_done, b_to;
    logic [15:0] b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    link_mode_sequencer dut_a (
        .iCLK_CORE           (clk),
        .iRST_LINK_FC_CORE_N (rst_n),
        .mode_req            (a_req),
        .mif_sop             (a_msop),
        .mif_eop             (a_meop),
        .mif_valid           (a_mval),
        .fmac_sop            (a_fsop),
        .fmac_eop            (a_feop),
        .fmac_valid          (a_fval),
        .mtip_enable         (a_en),
        .mode_busy           (a_busy),
        .mode_switch_done    (a_done),
        .drain_timeout       (a_to),
        .switch_cnt          (a_cnt)
    );

    link_mode_sequencer #(
        .DRAIN_TO   (8),
        .SETTLE_CYC (16)
    ) dut_b (
        .iCLK_CORE           (clk),
        .iRST_LINK_FC_CORE_N (rst_n),
        .mode_req            (b_req),
        .mif_sop             (b_msop),
        .mif_eop             (b_meop),
        .mif_valid           (b_mval),
        .fmac_sop            (b_fsop),
        .fmac_eop            (b_feop),
        .fmac_valid          (b_fval),
        .mtip_enable         (b_en),
        .mode_busy           (b_busy),
        .mode_switch_done    (b_done),
        .drain_timeout       (b_to),
        .switch_cnt          (b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {a_req, a_msop, a_meop, a_mval, a_fsop, a_feop, a_fval} = '0;
        {b_req, b_msop, b_meop, b_mval, b_fsop, b_feop, b_fval} = '0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_a_en",    a_en,    0);
        check("rst_a_busy",  a_busy,  0);
        check("rst_a_cnt",   a_cnt,   0);
        check("rst_a_done",  a_done,  0);
        check("rst_a_to",    a_to,    0);
        check("rst_b_en",    b_en,    0);
        check("rst_b_cnt",   b_cnt,   0);

        // Idle switch: toggle two edges after the request, done 16 cycles later
        a_req = 1'b1;
        tick();
        check("idle_drain_busy", a_busy, 1);
        check("idle_drain_en",   a_en,   0);
        tick();
        check("idle_toggle_en",  a_en,   1);
        check("idle_toggle_cnt", a_cnt,  1);
        check("idle_toggle_to",  a_to,   0);
        tick(15);
        check("idle_settle_done", a_done, 0);
        check("idle_settle_busy", a_busy, 1);
        tick();
        check("idle_done_pulse", a_done, 1);
        check("idle_done_busy",  a_busy, 0);
        tick();
        check("idle_done_clear", a_done, 0);

        // Frame drain: FMAC frame from cycle 0 to 40, request at cycle 5
        do_reset();
        a_fsop = 1'b1; a_fval = 1'b1;
        tick();
        a_fsop = 1'b0; a_fval = 1'b0;
        for (int c = 1; c < 40; c++) begin
            if (c == 5) a_req = 1'b1;
            tick();
        end
        check("drain_hold_en",   a_en,   0);
        check("drain_hold_busy", a_busy, 1);
        a_feop = 1'b1; a_fval = 1'b1;
        tick();
        a_feop = 1'b0; a_fval = 1'b0;
        check("drain_eop_edge_en", a_en, 0);
        tick();
        check("drain_toggle_en",  a_en,  1);
        check("drain_toggle_to",  a_to,  0);
        check("drain_toggle_cnt", a_cnt, 1);
        tick(16);
        check("drain_done", a_done, 1);

        // Single-beat sop&eop on the active path blocks the switch for that cycle
        do_reset();
        a_req = 1'b1;
        tick();
        a_fsop = 1'b1; a_feop = 1'b1; a_fval = 1'b1;
        tick();
        a_fsop = 1'b0; a_feop = 1'b0; a_fval = 1'b0;
        check("sop_block_en", a_en, 0);
        tick();
        check("sop_after_en", a_en, 1);

        // Withdrawn request while FMAC frame blocks the drain
        do_reset();
        a_fsop = 1'b1; a_fval = 1'b1;
        tick();
        a_fsop = 1'b0; a_fval = 1'b0;
        a_req = 1'b1;
        tick(4);
        check("wd_busy", a_busy, 1);
        check("wd_en",   a_en,   0);
        a_req = 1'b0;
        tick();
        check("wd_ret_busy", a_busy, 0);
        check("wd_ret_en",   a_en,   0);
        check("wd_ret_cnt",  a_cnt,  0);
        check("wd_ret_to",   a_to,   0);
        check("wd_ret_done", a_done, 0);
        tick(3);
        check("wd_late_done", a_done, 0);
        check("wd_late_busy", a_busy, 0);

        // Request toggled during SETTLE is deferred; inactive FMAC framing does not block
        do_reset();
        a_req = 1'b1;
        tick(2);
        check("ts_toggle_en", a_en, 1);
        tick(3);
        a_req = 1'b0;
        tick(12);
        check("ts_settle_busy", a_busy, 1);
        check("ts_settle_en",   a_en,   1);
        tick();
        check("ts_done",      a_done, 1);
        check("ts_done_busy", a_busy, 0);
        a_fsop = 1'b1; a_fval = 1'b1;
        tick();
        a_fsop = 1'b0; a_fval = 1'b0;
        check("ts_redrain_busy", a_busy, 1);
        check("ts_redrain_en",   a_en,   1);
        tick();
        check("ts_second_en",  a_en,  0);
        check("ts_second_cnt", a_cnt, 2);

        // Forced timeout with DRAIN_TO=8
        do_reset();
        b_fsop = 1'b1; b_fval = 1'b1;
        tick();
        b_fsop = 1'b0; b_fval = 1'b0;
        b_req = 1'b1;
        tick();
        check("to_drain_busy", b_busy, 1);
        tick(7);
        check("to_pre_en", b_en, 0);
        check("to_pre_to", b_to, 0);
        tick();
        check("to_toggle_en",  b_en,  1);
        check("to_toggle_to",  b_to,  1);
        check("to_toggle_cnt", b_cnt, 1);
        tick();
        check("to_pulse_clear", b_to, 0);

        // Saturation near 16'hFFFF, then reset mid-DRAIN
        do_reset();
        force dut_b.switch_cnt = 16'hFFFE;
        #1;
        release dut_b.switch_cnt;
        b_fsop = 1'b1; b_msop = 1'b1; b_fval = 1'b1; b_mval = 1'b1;
        tick();
        b_fsop = 1'b0; b_msop = 1'b0; b_fval = 1'b0; b_mval = 1'b0;
        b_req = 1'b1;
        tick(9);
        check("sat1_en",  b_en,  1);
        check("sat1_to",  b_to,  1);
        check("sat1_cnt", b_cnt, 16'hFFFF);
        tick(16);
        b_req = 1'b0;
        tick(9);
        check("sat2_en",  b_en,  0);
        check("sat2_to",  b_to,  1);
        check("sat2_cnt", b_cnt, 16'hFFFF);
        tick(16);
        b_req = 1'b1;
        tick(9);
        check("sat3_cnt", b_cnt, 16'hFFFF);
        tick(16);
        b_req = 1'b0;
        tick(4);
        check("rd_busy", b_busy, 1);
        check("rd_en",   b_en,   1);
        rst_n = 1'b0;
        #1;
        check("rd_async_en",   b_en,   0);
        check("rd_async_busy", b_busy, 0);
        check("rd_async_cnt",  b_cnt,  0);
        check("rd_async_to",   b_to,   0);
        check("rd_async_done", b_done, 0);
        tick();
        rst_n = 1'b1;
        tick(10);
        check("rd_after_to",   b_to,   0);
        check("rd_after_done", b_done, 0);
        check("rd_after_busy", b_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
